// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//   Serialises bytes onto a UART line as 8N1 frames: one start bit, eight data
//   bits sent LSB first, one stop bit. A small FIFO sits between the producer
//   and the line, so queued bytes go out back-to-back with no idle gap.
//
// Parameters
//   comm_clk_frequency : clk frequency in Hz
//   baud_rate          : line rate in bit/s
//   fifo_depth_log2    : log2 of FIFO depth (depth = 2**fifo_depth_log2)
//
// Ports
//   clk         in   system clock, all logic on posedge
//   reset_n     in   synchronous active-low reset
//   rx_new_byte in   one-cycle strobe: rx_byte is to be sent
//   rx_byte     in   [7:0] byte to send, valid while rx_new_byte is high
//   tx_ready    out  FIFO can accept a byte this cycle
//   tx_idle     out  FIFO empty and no frame in progress (registered)
//   uart_tx     out  serial line, idle high (registered)
//
// Optional feature macro: UART_TRANSMITTER_PARITY_EN
//   When defined, an even-parity bit is sent between the last data bit and the
//   stop bit (11-period frame). When undefined, no parity logic exists.
// -----------------------------------------------------------------------------
module uart_transmitter #(
  parameter int comm_clk_frequency = 100000000,
  parameter int baud_rate          = 115200,
  parameter int fifo_depth_log2    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_new_byte,
  input  logic [7:0] rx_byte,
  output logic       tx_ready,
  output logic       tx_idle,
  output logic       uart_tx
);

  localparam int DEPTH = 1 << fifo_depth_log2;
  // A depth-1 FIFO still needs a 1-bit pointer; wrap is explicit below.
  localparam int PTR_W = (fifo_depth_log2 > 0) ? fifo_depth_log2 : 1;
  localparam int CNT_W = fifo_depth_log2 + 1;

  localparam logic [15:0]      BAUD_DELAY = 16'(comm_clk_frequency / baud_rate - 1);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);

`ifdef UART_TRANSMITTER_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  state_t           r_state,    w_state_next;
  logic [CNT_W-1:0] r_count,    w_count_next;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [7:0]       r_shift,    w_shift_next;
  logic [2:0]       r_bit_idx,  w_bit_idx_next;
  logic [15:0]      r_baud_cnt, w_baud_cnt_next;
  logic             r_tx,       w_tx_next;
  logic             r_idle;
  logic [7:0]       r_mem [DEPTH];
`ifdef UART_TRANSMITTER_PARITY_EN
  logic             r_parity;
`endif

  logic       w_push;
  logic       w_pop;
  logic       w_fifo_empty;
  logic       w_period_end;
  logic [7:0] w_head;

  // tx_ready comes from the count before the edge, so a full FIFO refuses a
  // push even when a pop happens on the same edge.
  assign tx_ready     = (r_count < FULL_CNT);
  assign w_push       = rx_new_byte & tx_ready;
  assign w_fifo_empty = (r_count == '0);
  assign w_period_end = (r_baud_cnt == BAUD_DELAY);
  assign w_head       = r_mem[r_rd_ptr];

  assign tx_idle = r_idle;
  assign uart_tx = r_tx;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_idx_next  = r_bit_idx;
    w_tx_next       = r_tx;
    w_pop           = 1'b0;
    // The baud counter only runs while a frame is on the line.
    w_baud_cnt_next = (r_state == ST_IDLE || w_period_end) ? '0 : r_baud_cnt + 16'd1;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_tx_next    = 1'b0;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_period_end) begin
          w_tx_next      = r_shift[0];
          w_bit_idx_next = 3'd0;
          w_state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_period_end) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TRANSMITTER_PARITY_EN
            w_tx_next    = r_parity;
            w_state_next = ST_PARITY;
`else
            w_tx_next    = 1'b1;
            w_state_next = ST_STOP;
`endif
          end else begin
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_tx_next      = r_shift[1];
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TRANSMITTER_PARITY_EN
      ST_PARITY: begin
        if (w_period_end) begin
          w_tx_next    = 1'b1;
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_period_end) begin
          // Chain straight into the next start bit so frames stay contiguous.
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_head;
            w_tx_next    = 1'b0;
            w_state_next = ST_START;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_baud_cnt <= '0;
      r_tx       <= 1'b1;
      r_idle     <= 1'b1;
`ifdef UART_TRANSMITTER_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_shift    <= w_shift_next;
      r_bit_idx  <= w_bit_idx_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_tx       <= w_tx_next;
      r_idle     <= (w_state_next == ST_IDLE) && (w_count_next == '0);
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
`ifdef UART_TRANSMITTER_PARITY_EN
      if (w_pop)  r_parity <= ^w_head;
`endif
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the pointers and count
  // define which entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_byte;
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//   Scoreboard bench for uart_transmitter with a 16-cycle bit period.
//   The driver predicts, from arithmetic on push times, when each accepted
//   byte's frame must start, and queues the expected frame. A monitor watches
//   the line every cycle and compares each frame against the queue head; the
//   line must be high whenever no frame is due.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

  localparam int CLK_HZ  = 16;
  localparam int BAUD    = 1;
  localparam int DLOG2   = 2;
  localparam int DEPTH   = 1 << DLOG2;
  localparam int BIT_CYC = CLK_HZ / BAUD;
`ifdef UART_TRANSMITTER_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * BIT_CYC;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_new_byte = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_ready;
  logic       tx_idle;
  logic       uart_tx;

  uart_transmitter #(
    .comm_clk_frequency(CLK_HZ),
    .baud_rate         (BAUD),
    .fifo_depth_log2   (DLOG2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_new_byte(rx_new_byte),
    .rx_byte    (rx_byte),
    .tx_ready   (tx_ready),
    .tx_idle    (tx_idle),
    .uart_tx    (uart_tx)
  );

  always #5 clk = ~clk;

  // cyc = number of posedges so far; an action driven at a negedge lands on
  // edge cyc+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t sb_q[$];
  int   hist_e[$];
  int   hist_p[$];
  int   last_p;
  bit   has_last = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  bit          in_frame = 1'b0;
  int          f_start;
  int          f_bad;
  logic [10:0] f_exp;
  logic [10:0] f_act;
  logic [7:0]  f_data;
  int          idle_bad = 0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!reset_n) begin
        sb_q.delete();
        in_frame = 1'b0;
        check("reset_uart_tx", 32'(uart_tx), 32'd1);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_tx_idle", 32'(tx_idle), 32'd1);
      end else begin
        if (!in_frame && sb_q.size() > 0 && cyc > sb_q[0].start) begin
          check("frame_start_missed", 32'(cyc), 32'(sb_q[0].start));
          void'(sb_q.pop_front());
        end
        if (!in_frame && sb_q.size() > 0 && cyc == sb_q[0].start) begin
          exp_t e;
          e        = sb_q.pop_front();
          f_data   = e.data;
          f_start  = cyc;
          f_bad    = 0;
          f_act    = '1;
          f_exp    = '1;
          f_exp[0] = 1'b0;
          f_exp[8:1] = e.data;
`ifdef UART_TRANSMITTER_PARITY_EN
          f_exp[9] = ^e.data;
`endif
          in_frame = 1'b1;
        end
        if (in_frame) begin
          int off;
          off = cyc - f_start;
          if (uart_tx !== f_exp[off / BIT_CYC]) f_bad++;
          if (off % BIT_CYC == BIT_CYC / 2) f_act[off / BIT_CYC] = uart_tx;
          if (off == FRAME_CYC - 1) begin
            check($sformatf("frame_bits_%02h", f_data), 32'(f_act), 32'(f_exp));
            check($sformatf("frame_timing_%02h", f_data), 32'(f_bad), 32'd0);
            in_frame = 1'b0;
          end
        end else if (uart_tx !== 1'b1) begin
          idle_bad++;
        end
      end
    end
  end

  // ----------------------------------------------------------------- driver
  task automatic step(input bit push, input logic [7:0] b);
    int e;
    int cnt;
    bit exp_ready;
    bit exp_idle;
    @(negedge clk);
    e = cyc + 1;
    while (hist_p.size() > 0 && hist_p[0] + FRAME_CYC < cyc) begin
      void'(hist_e.pop_front());
      void'(hist_p.pop_front());
    end
    cnt      = 0;
    exp_idle = 1'b1;
    foreach (hist_e[i]) begin
      // Queued = pushed before edge e and not yet popped before edge e.
      if (hist_e[i] < e && hist_p[i] >= e) cnt++;
      if (hist_e[i] <= cyc && hist_p[i] + FRAME_CYC > cyc) exp_idle = 1'b0;
    end
    exp_ready = (cnt < DEPTH);
    check("tx_ready", 32'(tx_ready), 32'(exp_ready));
    check("tx_idle", 32'(tx_idle), 32'(exp_idle));
    rx_new_byte = push;
    rx_byte     = push ? b : 8'($urandom);
    if (push && exp_ready) begin
      int p;
      p = e + 1;
      if (has_last && last_p + FRAME_CYC > p) p = last_p + FRAME_CYC;
      hist_e.push_back(e);
      hist_p.push_back(p);
      last_p   = p;
      has_last = 1'b1;
      sb_q.push_back('{data: b, start: p});
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rx_new_byte = 1'b0;
    reset_n     = 1'b0;
    repeat (n) @(negedge clk);
    hist_e.delete();
    hist_p.delete();
    has_last = 1'b0;
    reset_n  = 1'b1;
  endtask

  initial begin
    int p3c;
    do_reset(3);

    // Quiet line after reset.
    repeat (1000) step(1'b0, 8'h00);

    // Single frame.
    step(1'b1, 8'hA5);
    repeat (200) step(1'b0, 8'h00);

    // Overfill a 4-deep FIFO: 0x06 must be refused.
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
    repeat (900) step(1'b0, 8'h00);

    // Reset during data bit 3 of 0x3C with two bytes queued behind it.
    step(1'b1, 8'h3C);
    p3c = last_p;
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    while (cyc < p3c + 4 * BIT_CYC + 5) step(1'b0, 8'h00);
    do_reset(2);
    repeat (400) step(1'b0, 8'h00);

    // Parity-relevant bytes back-to-back.
    step(1'b1, 8'h07);
    step(1'b1, 8'h03);
    repeat (400) step(1'b0, 8'h00);

    // Random burst that keeps the FIFO near full, then sparse random traffic.
    repeat (150) step(($urandom % 2) == 0, 8'($urandom));
    repeat (1500) step(($urandom % 40) == 0, 8'($urandom));

    // Drain, bounded.
    for (int i = 0; i < 8000 && (sb_q.size() > 0 || in_frame); i++) step(1'b0, 8'h00);
    repeat (5) step(1'b0, 8'h00);

    check("scoreboard_drained", 32'(sb_q.size()) + 32'(in_frame), 32'd0);
    check("idle_line_high", 32'(idle_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
